// File: rtl/digit_entry.sv
// digit_entry: four-digit keypad entry buffer with backspace, clear and enter/accept handling.
// Optional idle auto-clear is compiled in only when DIGIT_ENTRY_TIMEOUT_EN is defined.
module digit_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd250000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic [3:0]  digit_en,
  output logic [2:0]  count,
  output logic        full,
  output logic        code_valid,
  output logic [15:0] code,
  output logic        err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  state_t      state_r, state_nxt_s;
  logic [15:0] buf_r, buf_nxt_s;     // {digit3, digit2, digit1, digit0}
  logic [2:0]  count_r, count_nxt_s;
  logic [3:0]  en_r;
  logic        full_r;
  logic [15:0] code_r, code_nxt_s;
  logic        code_valid_r, code_valid_nxt_s;
  logic        err_r, err_nxt_s;
  logic        expire_s;

  function automatic logic [3:0] therm(input logic [2:0] n);
    case (n)
      3'd0:    therm = 4'b0000;
      3'd1:    therm = 4'b0001;
      3'd2:    therm = 4'b0011;
      3'd3:    therm = 4'b0111;
      3'd4:    therm = 4'b1111;
      default: therm = 4'b0000;
    endcase
  endfunction

  function automatic state_t state_of(input logic [2:0] n);
    case (n)
      3'd0:    state_of = EMPTY;
      3'd4:    state_of = FULL;
      default: state_of = ENTRY;
    endcase
  endfunction

`ifdef DIGIT_ENTRY_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 32'd1);

  logic [TW-1:0] idle_r;

  assign expire_s = (state_r != EMPTY) && (idle_r == T_LAST);

  // Idle counter: restarts on any key, on expiry, and whenever the buffer is empty
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_r <= {TW{1'b0}};
    end else if (key_valid || expire_s || (state_r == EMPTY)) begin
      idle_r <= {TW{1'b0}};
    end else begin
      idle_r <= idle_r + TW'(1);
    end
  end
`else
  assign expire_s = 1'b0;
`endif

  // Next-state decode: one key per cycle; a key always beats an idle expiry
  always_comb begin
    buf_nxt_s        = buf_r;
    count_nxt_s      = count_r;
    code_nxt_s       = code_r;
    code_valid_nxt_s = 1'b0;
    err_nxt_s        = 1'b0;
    if (key_valid) begin
      case (key_code)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
          if (state_r != FULL) begin
            buf_nxt_s   = {buf_r[11:0], key_code};
            count_nxt_s = count_r + 3'd1;
          end else begin
            buf_nxt_s   = buf_r;
          end
        end
        KEY_BKSP: begin
          if (state_r != EMPTY) begin
            buf_nxt_s   = {4'h0, buf_r[15:4]};
            count_nxt_s = count_r - 3'd1;
          end else begin
            buf_nxt_s   = buf_r;
          end
        end
        KEY_CLR: begin
          buf_nxt_s   = 16'h0000;
          count_nxt_s = 3'd0;
        end
        KEY_ENTER: begin
          if (state_r == FULL) begin
            code_nxt_s       = buf_r;
            code_valid_nxt_s = 1'b1;
            buf_nxt_s        = 16'h0000;
            count_nxt_s      = 3'd0;
          end else begin
            err_nxt_s        = 1'b1;
          end
        end
        default: begin
          buf_nxt_s = buf_r;
        end
      endcase
    end else if (expire_s) begin
      buf_nxt_s   = 16'h0000;
      count_nxt_s = 3'd0;
    end else begin
      buf_nxt_s   = buf_r;
    end
    state_nxt_s = state_of(count_nxt_s);
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= EMPTY;
      buf_r        <= 16'h0000;
      count_r      <= 3'd0;
      en_r         <= 4'b0000;
      full_r       <= 1'b0;
      code_r       <= 16'h0000;
      code_valid_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      buf_r        <= buf_nxt_s;
      count_r      <= count_nxt_s;
      en_r         <= therm(count_nxt_s);
      full_r       <= (state_nxt_s == FULL);
      code_r       <= code_nxt_s;
      code_valid_r <= code_valid_nxt_s;
      err_r        <= err_nxt_s;
    end
  end

  assign digit3     = buf_r[15:12];
  assign digit2     = buf_r[11:8];
  assign digit1     = buf_r[7:4];
  assign digit0     = buf_r[3:0];
  assign digit_en   = en_r;
  assign count      = count_r;
  assign full       = full_r;
  assign code       = code_r;
  assign code_valid = code_valid_r;
  assign err        = err_r;

endmodule

// File: tb/tb_digit_entry.sv
// tb_digit_entry: directed and randomized keypad stimulus checked against a queue-based
// reference model; pulse outputs are checked by a scoreboard monitor.
module tb_digit_entry;

  localparam int TC = 16;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  digit3, digit2, digit1, digit0;
  logic [3:0]  digit_en;
  logic [2:0]  count;
  logic        full;
  logic        code_valid;
  logic [15:0] code;
  logic        err;

  typedef struct {
    int cyc;
    bit is_code;
  } ev_t;

  ev_t         evq[$];
  int          mq[$];      // held digits, oldest first
  logic [15:0] m_code;
  int          idle;
  int          edge_count;
  int          checks;
  int          errors;

  digit_entry #(.TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .digit_en(digit_en), .count(count), .full(full),
    .code_valid(code_valid), .code(code), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_count, act, exp);
    end
  endtask

  function automatic int exp_digit(input int i);
    int n;
    n = mq.size();
    return (i < n) ? mq[n-1-i] : 0;
  endfunction

  // Reference model: effect of one cycle's inputs on the upcoming clock edge
  task automatic model_step(input bit v, input int k, input bit r);
    ev_t e;
    if (r) begin
      mq.delete();
      m_code = 16'h0000;
      idle = 0;
    end else if (v) begin
      idle = 0;
      if (k <= 9) begin
        if (mq.size() < 4) mq.push_back(k);
      end else if (k == 11) begin
        if (mq.size() > 0) void'(mq.pop_back());
      end else if (k == 12) begin
        mq.delete();
      end else if (k == 14) begin
        e.cyc = edge_count + 1;
        if (mq.size() == 4) begin
          m_code = {mq[0][3:0], mq[1][3:0], mq[2][3:0], mq[3][3:0]};
          mq.delete();
          e.is_code = 1'b1;
        end else begin
          e.is_code = 1'b0;
        end
        evq.push_back(e);
      end
    end else begin
`ifdef DIGIT_ENTRY_TIMEOUT_EN
      if (mq.size() > 0) begin
        if (idle == TC - 1) begin
          mq.delete();
          idle = 0;
        end else begin
          idle++;
        end
      end else begin
        idle = 0;
      end
`endif
    end
  endtask

  task automatic cycle(input bit v, input int k, input bit r);
    @(negedge clk);
    key_valid = v;
    key_code  = 4'(k);
    rst       = r;
    model_step(v, k, r);
  endtask

  task automatic key(input int k);
    cycle(1'b1, k, 1'b0);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
  endtask

  // Monitor: compares visible state every cycle and scores pulse outputs
  initial begin
    bit exp_pulse;
    ev_t e;
    forever begin
      @(posedge clk);
      edge_count++;
      #1;
      chk("digit3", 32'(digit3), 32'(exp_digit(3)));
      chk("digit2", 32'(digit2), 32'(exp_digit(2)));
      chk("digit1", 32'(digit1), 32'(exp_digit(1)));
      chk("digit0", 32'(digit0), 32'(exp_digit(0)));
      chk("count", 32'(count), 32'(mq.size()));
      chk("digit_en", 32'(digit_en), 32'((1 << mq.size()) - 1));
      chk("full", 32'(full), 32'(mq.size() == 4));
      chk("code", 32'(code), 32'(m_code));
      exp_pulse = (evq.size() > 0) && (evq[0].cyc == edge_count);
      if (code_valid || err || exp_pulse) begin
        if (!exp_pulse) begin
          chk("unexpected_pulse", {30'd0, code_valid, err}, 32'd0);
        end else begin
          e = evq.pop_front();
          chk("pulse", {30'd0, code_valid, err}, {30'd0, e.is_code, !e.is_code});
        end
      end
    end
  end

  initial begin
    int sel;
    int k;
    bit v;
    bit r;
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    m_code = 16'h0000;
    idle = 0;
    edge_count = 0;
    checks = 0;
    errors = 0;
    cycle(1'b0, 0, 1'b1);
    idle_n(1);
    // accepted code
    key(1); key(2); key(3); key(4); key(14); idle_n(2);
    // rejected enter
    key(5); key(6); key(14); idle_n(1); key(12);
    // digit while full, then backspace
    key(1); key(2); key(3); key(4); key(9); key(11); idle_n(1); key(12);
    // backspace when empty and an ignored code
    key(11); key(10); key(13); key(15); idle_n(1);
    // reset concurrent with a key
    key(1); key(2); cycle(1'b1, 3, 1'b1); idle_n(2);
`ifdef DIGIT_ENTRY_TIMEOUT_EN
    key(7); idle_n(TC + 2);
    key(7); idle_n(TC - 1); key(8); idle_n(3); key(12);
`endif
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 19);
      if (sel < 13) k = $urandom_range(0, 9);
      else if (sel < 15) k = 11;
      else if (sel < 16) k = 12;
      else if (sel < 18) k = 14;
      else k = 10 + 3 * $urandom_range(0, 1) + (($urandom_range(0, 1) == 1) ? 2 : 0);
      cycle(v, k, r);
      if ($urandom_range(0, 99) == 0) idle_n($urandom_range(TC - 2, TC + 3));
    end
    idle_n(3);
    @(negedge clk);
    chk("events_drained", 32'(evq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 250000000, meaning idle cycles before auto-clear (5 s at 50 MHz).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port key_valid  input  1  one-cycle strobe, key_code valid.
REQ-005 SHALL have port key_code  input  4  0x0-0x9 digit, 0xB backspace, 0xC clear, 0xE enter; other codes ignored.
REQ-006 SHALL have ports digit3, digit2, digit1, digit0  output  4 each  buffered digits, digit0 newest, each feeding one 7-seg decoder.
REQ-007 SHALL have port digit_en  output  4  bit i high when digit i is occupied; low means downstream blanks that position.
REQ-008 SHALL have port count  output  3  number of digits held, 0-4.
REQ-009 SHALL have port full  output  1  high when count==4.
REQ-010 SHALL have port code_valid  output  1  one-cycle pulse, code accepted.
REQ-011 SHALL have port code  output  16  {digit3,digit2,digit1,digit0} latched at acceptance.
REQ-012 SHALL have port err  output  1  one-cycle pulse on rejected enter.

Function
REQ-013 SHALL use states EMPTY (count 0), ENTRY (1-3), FULL (4); count, full and digit_en are registered and consistent with the state.
REQ-014 SHALL act only on cycles where key_valid=1; each key takes effect at the next rising edge (1-cycle latency).
REQ-015 SHALL, on a digit in EMPTY or ENTRY, shift the buffer left one position (digit3<=digit2, digit2<=digit1, digit1<=digit0, digit0<=key_code) and increment count.
REQ-016 SHALL ignore digits in FULL; the buffer is unchanged and there is no pulse.
REQ-017 SHALL, on backspace, shift right (digit0<=digit1, digit1<=digit2, digit2<=digit3, digit3<=0) and decrement count; backspace in EMPTY is ignored.
REQ-018 SHALL, on clear, zero all digits and set count to 0 from any state.
REQ-019 SHALL, on enter in FULL, latch code from the current digits, pulse code_valid for exactly one cycle, and clear the buffer to EMPTY in the same edge.
REQ-020 SHALL, on enter in EMPTY or ENTRY, pulse err for one cycle with the buffer unchanged.
REQ-021 SHALL hold code between acceptances; code_valid and err never assert in the same cycle.
REQ-022 SHALL zero unoccupied digit positions; digit_en equals the thermometer code of count (0000, 0001, 0011, 0111, 1111).
REQ-023 SHALL keep key_code values 0xA, 0xD and 0xF from altering any state.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, set all digits to 0, count 0, digit_en 0000, full 0, code 0x0000, code_valid 0, err 0, timeout counter 0, and state EMPTY.
REQ-025 SHALL give rst priority over a simultaneous key_valid or timeout; a key in the reset cycle is discarded.

Configuration
REQ-026 SHALL implement the idle auto-clear only when macro DIGIT_ENTRY_TIMEOUT_EN is defined.
REQ-027 With DIGIT_ENTRY_TIMEOUT_EN defined, a counter SHALL reset to 0 on any key_valid and increment each cycle while count>0; on reaching TIMEOUT_CYCLES-1 the buffer SHALL clear to EMPTY and the counter SHALL reset.
REQ-028 With DIGIT_ENTRY_TIMEOUT_EN defined, key_valid in the expiry cycle SHALL win: the key is processed and the counter restarts.
REQ-029 Without DIGIT_ENTRY_TIMEOUT_EN, no counter SHALL exist and the digits SHALL persist indefinitely.

Verification
REQ-030 Keys 1,2,3,4 then enter -> digits 1,2,3,4 / digit_en 1111 / full 1 before enter; then code=0x1234, a single code_valid pulse, count 0.
REQ-031 Keys 5,6 then enter -> err pulses once, count stays 2, digit1=5, digit0=6, no code_valid.
REQ-032 Keys 1,2,3,4,9 -> the 9 is ignored and digits stay 1234; then backspace -> digit2..0=1,2,3, digit3=0, count 3, digit_en 0111.
REQ-033 Backspace in EMPTY, then key 0xA -> no state change and all outputs stay at reset values.
REQ-034 With the macro defined and TIMEOUT_CYCLES=16: key 7, then idle -> buffer clears exactly 16 cycles after the key; a key on the expiry cycle is retained instead.
REQ-035 Keys 1,2, then rst held one cycle concurrent with key 3 -> all outputs at reset values and key 3 not captured.
